// File: rtl/bsram_pkg.sv
// Shared block-RAM geometry and reader state encoding, common to the reader and the memory writer.
package bsram_pkg;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sync_fifo_small.sv
// Small register FIFO: push lands at the clock edge, head is visible from registered state next cycle.
// Pushes while full are dropped and flagged by assertion; pops while empty are ignored.
module sync_fifo_small #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign count_o    = cnt_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (reset) !(push_i && full_o));

endmodule

// File: rtl/bsram_stream_reader.sv
// Streams len words from a pipelined BSRAM starting at base_adr; first word 4 cycles after start.
// Reads are credit-limited so issued-but-unpopped words never exceed FIFO_D; m_ready low stalls issue.
module bsram_stream_reader
    import bsram_pkg::*;
#(
    parameter int DATA_W = bsram_pkg::DATA_W,
    parameter int ADDR_W = bsram_pkg::ADDR_W,
    parameter int RD_LAT = 2,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int CW = $clog2(FIFO_D + 1);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] rd_adr_q, rd_adr_d, mem_adr_q, mem_adr_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d, out_cnt_q, out_cnt_d;
    logic [CW-1:0]     inflight_q, inflight_d, fifo_cnt;
    logic [RD_LAT-1:0] flag_q;
    logic              mem_ce_q, busy_q, busy_d, done_q, done_d;
    logic              issue, push, pop, fifo_empty, fifo_full;
    logic [CW:0]       occ;
    logic              credit_ok;

    assign push    = flag_q[RD_LAT-1];
    assign m_valid = ~fifo_empty;
    assign pop     = m_valid & m_ready;
    assign m_last  = m_valid & (out_cnt_q == (ADDR_W+1)'(1));

    // Issue is decided one cycle ahead of mem_ce, so a pop in the deciding cycle already frees its slot.
    assign occ       = (CW+1)'(fifo_cnt) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign credit_ok = occ < (CW+1)'(FIFO_D);

    always_comb begin
        state_d     = state_q;
        rd_adr_d    = rd_adr_q;
        mem_adr_d   = mem_adr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        issue       = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue       = 1'b1;
                        mem_adr_d   = base_adr;
                        rd_adr_d    = base_adr + ADDR_W'(1);
                        issue_cnt_d = len - (ADDR_W+1)'(1);
                        out_cnt_d   = len;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (issue_cnt_q == '0) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    issue       = 1'b1;
                    mem_adr_d   = rd_adr_q;
                    rd_adr_d    = rd_adr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q - (ADDR_W+1)'(1);
                    if (issue_cnt_q == (ADDR_W+1)'(1)) state_d = DRAIN;
                end
            end
            default: ;
        endcase
        if (state_q != IDLE && pop) begin
            out_cnt_d = out_cnt_q - (ADDR_W+1)'(1);
            if (out_cnt_q == (ADDR_W+1)'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        busy_d     = (state_d != IDLE);
        inflight_d = inflight_q + CW'(issue) - CW'(push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_adr_q    <= '0;
            mem_adr_q   <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= '0;
            flag_q      <= '0;
            mem_ce_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_adr_q    <= rd_adr_d;
            mem_adr_q   <= mem_adr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            flag_q      <= RD_LAT'({flag_q, mem_ce_q});
            mem_ce_q    <= issue;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign mem_ce  = mem_ce_q;
    assign mem_oce = busy_q;
    assign mem_wre = 1'b0;
    assign mem_adr = mem_adr_q;

    sync_fifo_small #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (mem_dout),
        .pop_i      (pop),
        .head_dat_o (m_data),
        .count_o    (fifo_cnt),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

endmodule

// File: tb/tb_bsram_stream_reader.sv
// Directed and randomized bench for bsram_stream_reader against a pipelined BSRAM model preloaded with mem[i]=i+1.
module tb_bsram_stream_reader;

    localparam int DW = 18, AW = 7, RD_LAT = 2, FIFO_D = 4, DEPTH = 128;

    logic          clk = 1'b0;
    logic          reset, start, m_ready;
    logic [AW-1:0] base_adr;
    logic [AW:0]   len;
    logic          busy, done, mem_ce, mem_oce, mem_wre, m_valid, m_last;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_dout, m_data, rd_reg;
    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    bsram_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .reset(reset), .start(start), .base_adr(base_adr), .len(len),
        .busy(busy), .done(done), .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre),
        .mem_adr(mem_adr), .mem_dout(mem_dout), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    // Pipeline-mode memory: address captured on ce, output register loads on oce.
    always @(posedge clk) begin
        if (reset) begin
            rd_reg   <= '0;
            mem_dout <= '0;
        end else begin
            if (mem_ce)  rd_reg   <= mem[mem_adr];
            if (mem_oce) mem_dout <= rd_reg;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ce_total = 0, pop_total = 0, busy_cnt = 0, out_base = 0;
    int got_dat[$], got_cyc[$], ce_adr[$], ce_cyc[$], done_cyc[$], out_hist[$];
    bit got_last[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_ce) begin
                ce_total++;
                ce_adr.push_back(int'(mem_adr));
                ce_cyc.push_back(cyc);
            end
            out_hist.push_back(ce_total - pop_total - out_base);
            if (m_valid && m_ready) begin
                got_dat.push_back(int'(m_data));
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
                pop_total++;
            end
            if (done) done_cyc.push_back(cyc);
            if (busy) busy_cnt++;
        end
    end

    int n_cmp = 0, n_fail = 0;
    int t0, t1, md, mc, mdn, mo, mb;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1000;
    endfunction

    task automatic mark();
        md  = got_dat.size();
        mc  = ce_adr.size();
        mdn = done_cyc.size();
        mo  = out_hist.size();
        mb  = busy_cnt;
    endtask

    task automatic do_start(input int b, input int n, output int t);
        @(posedge clk); #1;
        base_adr = AW'(b);
        len      = (AW+1)'(n);
        start    = 1'b1;
        t        = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        int n0 = done_cyc.size();
        int k  = 0;
        while (done_cyc.size() == n0 && k < budget) begin
            @(posedge clk); #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            k++;
        end
        m_ready = 1'b1;
        chk({tag, "_done_seen"}, int'(done_cyc.size() > n0), 1);
    endtask

    // Reference: the burst must deliver mem[(base+i) mod depth] in order, last only on word n-1.
    task automatic chk_seq(input string tag, input int b, input int n);
        int bad = 0;
        chk({tag, "_words"}, got_dat.size() - md, n);
        for (int i = 0; i < n; i++) begin
            int e;
            e = int'(mem[(b + i) % DEPTH]);
            if (md + i >= got_dat.size()) bad++;
            else if (got_dat[md + i] !== e || got_last[md + i] !== (i == n - 1)) bad++;
        end
        chk({tag, "_order_last"}, bad, 0);
    endtask

    function automatic int max_out(input int from);
        int mx = 0;
        for (int i = from; i < out_hist.size(); i++) if (out_hist[i] > mx) mx = out_hist[i];
        return mx;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; base_adr = '0; len = '0; m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ce", int'(mem_ce), 0);
        chk("rst_oce", int'(mem_oce), 0);
        chk("rst_wre", int'(mem_wre), 0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_last", int'(m_last), 0);
        chk("rst_adr", int'(mem_adr), 0);
        chk("rst_data", int'(m_data), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Basic 3-word burst with exact cycle timing
        mark();
        do_start(0, 3, t0);
        wait_done("t1", 40, 0);
        chk_seq("t1", 0, 3);
        chk("t1_first_ce", qat(ce_cyc, mc) - t0, 1);
        chk("t1_ce_n", ce_adr.size() - mc, 3);
        chk("t1_first_word", qat(got_cyc, md) - t0, 4);
        chk("t1_last_word", qat(got_cyc, md + 2) - t0, 6);
        chk("t1_done_cyc", qat(done_cyc, mdn) - t0, 7);
        repeat (3) @(posedge clk); #1;
        chk("t1_done_once", done_cyc.size() - mdn, 1);
        chk("t1_busy_cycles", busy_cnt - mb, 6);

        // Address wrap at the top of memory
        mark();
        do_start(126, 4, t0);
        wait_done("t2", 40, 0);
        chk_seq("t2", 126, 4);
        chk("t2_adr0", qat(ce_adr, mc), 126);
        chk("t2_adr1", qat(ce_adr, mc + 1), 127);
        chk("t2_adr2", qat(ce_adr, mc + 2), 0);
        chk("t2_adr3", qat(ce_adr, mc + 3), 1);

        // Backpressure: credits stop issue at FIFO_D outstanding
        mark();
        m_ready = 1'b0;
        do_start(20, 16, t0);
        repeat (20) @(posedge clk); #1;
        chk("t3_ce_stalled", ce_adr.size() - mc, FIFO_D);
        chk("t3_no_words", got_dat.size() - md, 0);
        m_ready = 1'b1;
        wait_done("t3", 80, 0);
        chk_seq("t3", 20, 16);
        chk("t3_ce_total", ce_adr.size() - mc, 16);
        chk("t3_max_out", max_out(mo), FIFO_D);

        // Full-memory burst with random backpressure
        mark();
        do_start(0, 128, t0);
        wait_done("t4", 2000, 1);
        chk_seq("t4", 0, 128);
        chk("t4_out_bound", int'(max_out(mo) <= FIFO_D), 1);

        // Random base/length bursts against the reference model
        for (int r = 0; r < 3; r++) begin
            int rb, rl;
            rb = int'($urandom_range(0, DEPTH - 1));
            rl = int'($urandom_range(1, DEPTH));
            mark();
            do_start(rb, rl, t0);
            wait_done("t4r", 2000, 1);
            chk_seq("t4r", rb, rl);
            chk("t4r_ce_n", ce_adr.size() - mc, rl);
            chk("t4r_out_bound", int'(max_out(mo) <= FIFO_D), 1);
        end

        // Zero-length start
        mark();
        do_start(3, 0, t0);
        repeat (4) @(posedge clk); #1;
        chk("t5_ce", ce_adr.size() - mc, 0);
        chk("t5_busy", busy_cnt - mb, 0);
        chk("t5_done_n", done_cyc.size() - mdn, 1);
        chk("t5_done_cyc", qat(done_cyc, mdn) - t0, 1);

        // Start while busy is ignored
        mark();
        do_start(10, 5, t0);
        @(posedge clk); #1;
        do_start(50, 7, t1);
        wait_done("t5b", 60, 0);
        repeat (20) @(posedge clk); #1;
        chk_seq("t5b", 10, 5);
        chk("t5b_ce_n", ce_adr.size() - mc, 5);
        chk("t5b_done_n", done_cyc.size() - mdn, 1);

        // Reset in cycle 5 of a 10-word burst
        do_start(0, 10, t0);
        repeat (4) @(posedge clk); #1;
        chk("t6_pre_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_ce", int'(mem_ce), 0);
        chk("t6_oce", int'(mem_oce), 0);
        chk("t6_valid", int'(m_valid), 0);
        chk("t6_last", int'(m_last), 0);
        chk("t6_adr", int'(mem_adr), 0);
        chk("t6_data", int'(m_data), 0);
        chk("t6_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_base = ce_total - pop_total;
        mark();
        repeat (15) @(posedge clk); #1;
        chk("t6_no_done", done_cyc.size() - mdn, 0);
        chk("t6_no_words", got_dat.size() - md, 0);
        mark();
        do_start(40, 2, t0);
        wait_done("t6b", 40, 0);
        chk_seq("t6b", 40, 2);
        chk("t6b_done_cyc", qat(done_cyc, mdn) - t0, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bsram_stream_reader.md
# bsram_stream_reader

Read-side sequencer for an 18-bit × 128-word single-port block RAM in pipeline (output-register) mode. On a start command it reads `len` consecutive words from `base_adr`, wrapping modulo the depth. It presents the words in order on a valid/ready stream with a last flag. It sits between a coefficient or sample memory, loaded by a separate writer, and the DSP datapath that consumes the samples.

## Interface
Parameters:
- `DATA_W`, 18, memory and stream word width
- `ADDR_W`, 7, memory address width; depth = 2**ADDR_W
- `RD_LAT`, 2, cycles from a read-issue cycle to valid `mem_dout`
- `FIFO_D`, 4, output buffer depth; must be ≥ RD_LAT+1

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle command strobe, accepted only in IDLE
- `base_adr`  in  ADDR_W  first address, sampled with `start`
- `len`  in  ADDR_W+1  word count, 0..2**ADDR_W, sampled with `start`
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle pulse after the last word is accepted downstream
- `mem_ce`  out  1  memory clock enable; high only on read-issue cycles
- `mem_oce`  out  1  output-register enable; high whenever `busy`
- `mem_wre`  out  1  constant 0
- `mem_adr`  out  ADDR_W  read address, registered
- `mem_dout`  in  DATA_W  memory read data
- `m_data`  out  DATA_W  stream data, driven from the buffer head
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  downstream ready
- `m_last`  out  1  high with the final word of a burst

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, `start`=1, `len`≠0: latch `base_adr` into `rd_adr` and `len` into `issue_cnt` and `out_cnt`. Next state RUN.
- IDLE, `start`=1, `len`=0: no memory access. Pulse `done` next cycle. Stay IDLE; `busy` never rises.
- `start` while not in IDLE is ignored. No queuing.
- RUN: issue a read when `issue_cnt`≠0 and `fifo_cnt + inflight < FIFO_D`. Issue drives `mem_ce`=1 and `mem_adr`=`rd_adr`, then increments `rd_adr` (wraps 2**ADDR_W−1 → 0) and decrements `issue_cnt`. `inflight` counts issued reads not yet returned.
- A shift register of RD_LAT issue flags marks the cycles where `mem_dout` is valid. In those cycles, `mem_dout` is pushed into the buffer. The credit rule above guarantees no overflow; a push into a full buffer is an assertion failure.
- RUN → DRAIN when `issue_cnt` reaches 0.
- Stream: `m_valid` = buffer not empty. A word pops on `m_valid & m_ready`, which decrements `out_cnt`. `m_last` = `m_valid & (out_cnt==1)`.
- DRAIN → IDLE on the pop that takes `out_cnt` to 0. `done` pulses in the following cycle and `busy` falls in that same cycle.
- A push and a pop in the same cycle leave `fifo_cnt` unchanged.
- Values after `reset`: IDLE; `busy`, `done`, `mem_ce`, `mem_oce`, `mem_wre`, `m_valid`, `m_last` = 0; `mem_adr` = 0; `m_data` = 0; counters, buffer, and issue flags cleared. A reset mid-burst abandons the burst with no `done`.

## Timing
- `start` in cycle 0 → first `mem_ce` in cycle 1.
- Data from an issue in cycle t is pushed at the edge ending cycle t+RD_LAT and appears on `m_valid`/`m_data` in cycle t+RD_LAT+1.
- With `m_ready` held at 1, the first word appears in cycle RD_LAT+2 = 4. Throughput is one word per cycle. The last word of `len`=N appears in cycle N+3, and `done` pulses in cycle N+4.
- With `m_ready`=0, at most FIFO_D reads are outstanding plus buffered, after which `mem_ce` stops. Issue resumes the cycle after a pop frees a credit.
- All outputs are registered, except `m_data`, `m_valid` and `m_last`, which are decoded from registered buffer state.

## Structure
- A shared package `bsram_pkg` holds:
  - `DATA_W` and `ADDR_W` defaults, shared with the memory writer;
  - the state enum `rd_state_t` {IDLE, RUN, DRAIN}.
- One sub-module, `sync_fifo_small`: parameterised depth/width register FIFO with push, pop, count, empty and full. The sequencer, credit logic and latency shift register stay in the top module.

## Test plan
- Memory preloaded with mem[i]=i+1. `start`, `base_adr`=0, `len`=3, `m_ready`=1 → words 1, 2, 3 in cycles 4–6; `m_last` with 3; `done` in cycle 7.
- `base_adr`=126, `len`=4 → `mem_adr` 126, 127, 0, 1; data 127, 128, 1, 2.
- `len`=16 with `m_ready`=0 for 20 cycles, then 1 → exactly 4 `mem_ce` pulses before the stall. All 16 words arrive in order with no loss or duplicates, and the buffer never overflows.
- Random `m_ready` (50%), `len`=128 → output sequence equals mem[0..127]; `m_last` is high on the 128th word only.
- `len`=0 → no `mem_ce`, `busy` stays 0, `done` pulses one cycle after `start`. A second `start` while `busy` is ignored.
- `reset` pulse in cycle 5 of a `len`=10 burst → all outputs return to reset values in the same cycle and no `done` follows. A fresh `len`=2 burst then completes normally.
